// File: rtl/fetch_pipe_ctrl_if.sv
// Handshake bundle between the fetch sequencing controller and the pipeline.
// The pipeline raises event levels/pulses; the controller answers with
// stall, flush, clear and PC-enable controls in the same cycle.
interface fetch_pipe_ctrl_if;
  logic       icache_miss;
  logic       dcache_miss;
  logic       load_use;
  logic       branch_taken;
  logic       jalr_taken;
  logic       wfi_id;
  logic       irq_pending;
  logic       address_rst;
  logic       Istall;
  logic       Dstall;
  logic       wfi_stall;
  logic       lu_stall;
  logic       flush;
  logic       flush_jalr;
  logic       pc_en;
  logic [1:0] ctrl_state;

  // Controller side: consumes events, drives pipeline controls.
  modport master (
    input  icache_miss, dcache_miss, load_use, branch_taken, jalr_taken,
           wfi_id, irq_pending,
    output address_rst, Istall, Dstall, wfi_stall, lu_stall, flush,
           flush_jalr, pc_en, ctrl_state
  );

  // Pipeline side: produces events, obeys controls.
  modport slave (
    output icache_miss, dcache_miss, load_use, branch_taken, jalr_taken,
           wfi_id, irq_pending,
    input  address_rst, Istall, Dstall, wfi_stall, lu_stall, flush,
           flush_jalr, pc_en, ctrl_state
  );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Sequencing controller for the PC and IF/ID registers. Holds the PC in
// reset for RST_HOLD cycles, turns cache misses, load-use hazards and WFI
// into stalls, and remembers redirects that land during a stall so their
// flush is emitted on the first unstalled cycle.
module fetch_pipe_ctrl #(
  parameter int unsigned RST_HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  fetch_pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WFI  = 2'd2,
    WAKE = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] boot_cnt;
  logic       pend_br;
  logic       pend_jalr;

  logic active;
  logic istall;
  logic dstall;
  logic wfi_s;
  logic stall;
  logic fl;
  logic flj;
  logic lu;
  logic pce;
  logic go_wfi;

  // Control decode: everything is a function of registered state and the
  // current event inputs; BOOT forces all controls off.
  always_comb begin
    active = (state != BOOT);
    istall = active & bus.icache_miss;
    dstall = active & bus.dcache_miss;
    wfi_s  = (state == WFI);
    stall  = istall | dstall | wfi_s;
    fl     = active & ~stall & (bus.branch_taken | pend_br);
    flj    = active & ~stall & (bus.jalr_taken | pend_jalr);
    // A flush kills the dependent instruction, so no bubble is needed.
    lu     = active & bus.load_use & ~stall & ~fl & ~flj;
    pce    = ((state == RUN) | (state == WAKE)) & ~stall & ~lu;
    // WFI with an interrupt already pending retires as a NOP.
    go_wfi = (state == RUN) & bus.wfi_id & ~stall & ~lu & ~fl & ~flj
             & ~bus.irq_pending;
  end

  assign bus.address_rst = ~active;
  assign bus.Istall      = istall;
  assign bus.Dstall      = dstall;
  assign bus.wfi_stall   = wfi_s;
  assign bus.lu_stall    = lu;
  assign bus.flush       = fl;
  assign bus.flush_jalr  = flj;
  assign bus.pc_en       = pce;
  assign bus.ctrl_state  = state;

  // State, boot counter and redirect-pending latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      boot_cnt  <= 4'(RST_HOLD);
      pend_br   <= 1'b0;
      pend_jalr <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt <= 4'd1) state <= RUN;
          else                  boot_cnt <= boot_cnt - 4'd1;
        end
        RUN:  if (go_wfi) state <= WFI;
        WFI:  if (bus.irq_pending) state <= WAKE;
        WAKE: state <= RUN;
        default: state <= BOOT;
      endcase

      // One flush per latch: a repeat pulse while set is absorbed, and the
      // latch drops on the cycle its flush goes out.
      if (active) begin
        if (fl)                              pend_br <= 1'b0;
        else if (bus.branch_taken && stall)  pend_br <= 1'b1;
        if (flj)                             pend_jalr <= 1'b0;
        else if (bus.jalr_taken && stall)    pend_jalr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl: reset/boot timing, redirects held
// across I- and D-side stalls, load-use bubble, WFI sleep/wake and reset
// in the middle of a stall.
module tb_fetch_pipe_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_pipe_ctrl_if bus ();

  fetch_pipe_ctrl #(.RST_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed control vector:
  // {address_rst, Istall, Dstall, wfi_stall, lu_stall, flush, flush_jalr, pc_en, ctrl_state}
  function automatic logic [9:0] obs();
    return {bus.address_rst, bus.Istall, bus.Dstall, bus.wfi_stall,
            bus.lu_stall, bus.flush, bus.flush_jalr, bus.pc_en,
            bus.ctrl_state};
  endfunction

  function automatic logic [9:0] ev(logic a, logic i, logic d, logic w,
                                    logic lu, logic f, logic fj, logic pc,
                                    logic [1:0] st);
    return {a, i, d, w, lu, f, fj, pc, st};
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (a,I,D,w,lu,f,fj,pc,st)",
             tag, o, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_events();
    bus.icache_miss  = 1'b0;
    bus.dcache_miss  = 1'b0;
    bus.load_use     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jalr_taken   = 1'b0;
    bus.wfi_id       = 1'b0;
    bus.irq_pending  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear_events();

    // ---- reset and boot ----
    sample(); check("in_reset", ev(1,0,0,0,0,0,0,0,2'd0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sample(); check("boot_c1", ev(1,0,0,0,0,0,0,0,2'd0));
    next(); sample(); check("boot_c2", ev(1,0,0,0,0,0,0,0,2'd0));
    next(); sample(); check("run_c3", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- branch during an I-cache miss ----
    next(); bus.icache_miss = 1'b1;
    sample(); check("imiss_c1", ev(0,1,0,0,0,0,0,0,2'd1));
    next(); bus.branch_taken = 1'b1;
    sample(); check("imiss_c2_br", ev(0,1,0,0,0,0,0,0,2'd1));
    next(); bus.branch_taken = 1'b0;
    sample(); check("imiss_c3", ev(0,1,0,0,0,0,0,0,2'd1));
    next();
    sample(); check("imiss_c4", ev(0,1,0,0,0,0,0,0,2'd1));
    next(); bus.icache_miss = 1'b0;
    sample(); check("imiss_replay", ev(0,0,0,0,0,1,0,1,2'd1));
    next();
    sample(); check("imiss_after", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- load-use bubble, then load-use killed by jalr ----
    next(); bus.load_use = 1'b1;
    sample(); check("lu_bubble", ev(0,0,0,0,1,0,0,0,2'd1));
    next(); bus.jalr_taken = 1'b1;
    sample(); check("lu_with_jalr", ev(0,0,0,0,0,0,1,1,2'd1));
    next(); bus.load_use = 1'b0; bus.jalr_taken = 1'b0;
    sample(); check("lu_after", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- WFI sleep, redirect while asleep, wake ----
    next(); bus.wfi_id = 1'b1;
    sample(); check("wfi_issue", ev(0,0,0,0,0,0,0,1,2'd1));
    next(); bus.wfi_id = 1'b0;
    sample(); check("wfi_sleep", ev(0,0,0,1,0,0,0,0,2'd2));
    next(); bus.icache_miss = 1'b1; bus.branch_taken = 1'b1;
    sample(); check("wfi_br_imiss", ev(0,1,0,1,0,0,0,0,2'd2));
    next(); bus.icache_miss = 1'b0; bus.branch_taken = 1'b0;
    sample(); check("wfi_hold", ev(0,0,0,1,0,0,0,0,2'd2));
    next(); bus.irq_pending = 1'b1;
    sample(); check("wfi_irq", ev(0,0,0,1,0,0,0,0,2'd2));
    next(); bus.irq_pending = 1'b0;
    sample(); check("wake_flush", ev(0,0,0,0,0,1,0,1,2'd3));
    next();
    sample(); check("wake_to_run", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- WFI with interrupt already pending is a NOP ----
    next(); bus.wfi_id = 1'b1; bus.irq_pending = 1'b1;
    sample(); check("wfi_nop", ev(0,0,0,0,0,0,0,1,2'd1));
    next(); bus.wfi_id = 1'b0; bus.irq_pending = 1'b0;
    sample(); check("wfi_nop_after", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- simultaneous redirects under a D-miss ----
    next(); bus.dcache_miss = 1'b1;
    sample(); check("dmiss_c1", ev(0,0,1,0,0,0,0,0,2'd1));
    next(); bus.branch_taken = 1'b1; bus.jalr_taken = 1'b1;
    sample(); check("dmiss_both", ev(0,0,1,0,0,0,0,0,2'd1));
    next(); bus.branch_taken = 1'b0; bus.jalr_taken = 1'b0;
    sample(); check("dmiss_hold", ev(0,0,1,0,0,0,0,0,2'd1));
    next(); bus.dcache_miss = 1'b0;
    sample(); check("dmiss_replay", ev(0,0,0,0,0,1,1,1,2'd1));
    next();
    sample(); check("dmiss_after", ev(0,0,0,0,0,0,0,1,2'd1));

    // ---- rerun: reset mid-stall drops the pending redirect ----
    next(); bus.dcache_miss = 1'b1; bus.branch_taken = 1'b1;
    sample(); check("rerun_dmiss_br", ev(0,0,1,0,0,0,0,0,2'd1));
    next(); bus.branch_taken = 1'b0;
    rst = 1'b0;
    #1 check("async_reset", ev(1,0,0,0,0,0,0,0,2'd0));
    next(); next();
    rst = 1'b1; bus.branch_taken = 1'b1;
    sample(); check("reboot_c1_ignored", ev(1,0,0,0,0,0,0,0,2'd0));
    next(); bus.branch_taken = 1'b0;
    sample(); check("reboot_c2", ev(1,0,0,0,0,0,0,0,2'd0));
    next(); bus.dcache_miss = 1'b0;
    sample(); check("reboot_run_noflush", ev(0,0,0,0,0,0,0,1,2'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Sequencing controller for the IF/ID pipeline register and the PC register.
- Generates address_rst, Istall, Dstall, wfi_stall, flush, flush_jalr, the load-use bubble and the PC write enable from cache-miss, hazard, redirect and WFI/interrupt events.
- Holds redirects that arrive during a cache stall and replays them on the first unstalled cycle, so no branch or jalr flush is lost while the IF/ID register is frozen.

Parameters:
- RST_HOLD, 2: cycles address_rst stays high after reset release (range 1..15).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- icache_miss  input  1  I-cache cannot deliver an instruction this cycle
- dcache_miss  input  1  D-cache access outstanding in MEM
- load_use  input  1  ID source register matches the destination of a load in EX
- branch_taken  input  1  single-cycle pulse: taken branch/jal resolved in EX
- jalr_taken  input  1  single-cycle pulse: jalr resolved in EX
- wfi_id  input  1  WFI instruction present in ID
- irq_pending  input  1  enabled interrupt pending (level)
- address_rst  output  1  synchronous clear of the PC and IF/ID register
- Istall  output  1  I-side stall to the pipeline registers
- Dstall  output  1  D-side stall to the pipeline registers
- wfi_stall  output  1  core sleeping in WFI
- lu_stall  output  1  load-use bubble: hold PC and IF/ID, insert NOP into ID/EX
- flush  output  1  branch flush of the IF/ID register
- flush_jalr  output  1  jalr flush of the IF/ID register
- pc_en  output  1  PC register write enable
- ctrl_state  output  2  current FSM state (debug)

Behaviour:
- States: BOOT=0, RUN=1, WFI=2, WAKE=3.
- While rst=0:
  - state=BOOT and boot counter=RST_HOLD.
  - pend_br=pend_jalr=0.
  - address_rst=1; all other outputs 0.
- BOOT:
  - address_rst=1; all stalls, flushes and pc_en are 0.
  - Counter decrements each cycle; at 1, next state is RUN. address_rst is high for exactly RST_HOLD cycles after rst rises.
  - All event inputs are ignored.
- Define stall = Istall | Dstall | wfi_stall.
- In RUN, WAKE and WFI:
  - Istall = icache_miss.
  - Dstall = dcache_miss.
  - Both are combinational, with zero latency.
- Redirect pending latches:
  - If branch_taken=1 and stall=1, set pend_br.
  - If jalr_taken=1 and stall=1, set pend_jalr.
  - Each latch clears on the cycle its flush is emitted.
- Flush generation:
  - flush = !stall & (branch_taken | pend_br).
  - flush_jalr = !stall & (jalr_taken | pend_jalr).
  - Both may be high in the same cycle.
  - A new pulse arriving while the same latch is already set is absorbed: one flush per latch.
- lu_stall = load_use & !stall & !flush & !flush_jalr. A flush kills the dependent instruction, so no bubble is needed.
- pc_en = (state∈{RUN,WAKE}) & !stall & !lu_stall. A flush with no stall always gives pc_en=1 (redirect).
- RUN → WFI transition:
  - Taken when wfi_id=1, stall=0, lu_stall=0, no flush and irq_pending=0.
  - If irq_pending=1 in that cycle, WFI executes as a NOP and the state stays RUN.
- WFI state:
  - wfi_stall=1; pc_en=0.
  - Istall and Dstall still follow the cache inputs, so an outstanding D-miss still completes.
  - Branch/jalr pulses set the pending latches.
  - irq_pending=1 → WAKE next cycle.
- WAKE state:
  - wfi_stall=0, for one cycle.
  - Pending flushes are emitted here if there is no cache stall.
  - Next state is RUN.
- Reset mid-operation: asynchronous return to BOOT; pending latches are lost by design.
- Outputs are combinational from registered state and current inputs. No output is combinationally derived from itself.

Test Plan:
- Reset sequence: hold rst=0 for 3 cycles, then release with RST_HOLD=2 → address_rst=1 during reset and for exactly 2 cycles after release; ctrl_state=1 on cycle 3; pc_en=1 from cycle 3 with no misses.
- Flush during a cache stall: in RUN, drive icache_miss=1 for 4 cycles and pulse branch_taken in cycle 2 → flush=0 during the miss; flush=1 for exactly 1 cycle, the first cycle icache_miss=0; pc_en=1 in that cycle.
- Load-use bubble: load_use=1 for 1 cycle → lu_stall=1, pc_en=0, Istall=Dstall=0. Load_use=1 together with jalr_taken=1 → flush_jalr=1, lu_stall=0, pc_en=1.
- WFI sleep and wake: wfi_id=1 with irq_pending=0 → ctrl_state=2 next cycle, wfi_stall=1 and pc_en=0 until irq_pending rises. Then exactly 1 cycle of ctrl_state=3, then ctrl_state=1.
- WFI with interrupt already pending: wfi_id=1 with irq_pending=1 → ctrl_state stays 1, wfi_stall never asserts.
- Simultaneous redirects under D-stall: during dcache_miss=1, pulse branch_taken and jalr_taken in the same cycle → both pending. After dcache_miss falls, flush=flush_jalr=1 in the same single cycle. Assert rst=0 mid-stall on a rerun → pending flush never emitted; address_rst=1 immediately.
